// File: rtl/fetch_stall_unit.sv
// Instruction-fetch stage: owns the PC, the IF/ID register and the imem handshake.
// Honours stall (hold PC and IF/ID) and flush (redirect and squash), and buffers a word that completes under a stall.
module fetch_stall_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INSN = 16'h0800
) (
    input  logic        FS_clk,
    input  logic        FS_rst,
    input  logic        FS_stall,
    input  logic        FS_flush,
    input  logic [15:0] FS_branchTarget,
    output logic        FS_imemReq,
    output logic [15:0] FS_imemAddr,
    input  logic [15:0] FS_imemData,
    input  logic        FS_imemReady,
    output logic [15:0] FS_PC,
    output logic [15:0] FS_instruction,
    output logic [15:0] FS_pcPlus1,
    output logic        FS_valid
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fs_state_e;

    fs_state_e   state_q, state_d;
    logic [15:0] pc_q;
    logic [15:0] insn_q;
    logic [15:0] pc_plus1_q;
    logic        valid_q;
    logic [15:0] buf_q;
    logic [15:0] pc_inc;

    assign pc_inc = pc_q + 16'd1;

    // State register
    always_ff @(posedge FS_clk) begin
        if (FS_rst)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (!FS_flush && FS_stall && FS_imemReady) state_d = HOLD;
            HOLD:  if (FS_flush || !FS_stall)                 state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Output decode: a request is only outstanding while fetching out of reset
    always_comb begin
        FS_imemReq = 1'b0;
        if (!FS_rst && state_q == FETCH)
            FS_imemReq = 1'b1;
    end

    // PC, IF/ID and capture buffer
    always_ff @(posedge FS_clk) begin
        if (FS_rst) begin
            pc_q       <= RESET_PC;
            insn_q     <= NOP_INSN;
            pc_plus1_q <= 16'h0000;
            valid_q    <= 1'b0;
            buf_q      <= 16'h0000;
        end else if (FS_flush) begin
            // Redirect; any completing or buffered word is dropped, pcPlus1 left as is
            pc_q    <= FS_branchTarget;
            insn_q  <= NOP_INSN;
            valid_q <= 1'b0;
            buf_q   <= 16'h0000;
        end else if (FS_stall) begin
            if (state_q == FETCH && FS_imemReady)
                buf_q <= FS_imemData;
        end else if (state_q == HOLD) begin
            insn_q     <= buf_q;
            pc_plus1_q <= pc_inc;
            valid_q    <= 1'b1;
            pc_q       <= pc_inc;
        end else if (FS_imemReady) begin
            insn_q     <= FS_imemData;
            pc_plus1_q <= pc_inc;
            valid_q    <= 1'b1;
            pc_q       <= pc_inc;
        end else begin
            // Memory wait: feed a bubble, keep the request on the same PC
            insn_q  <= NOP_INSN;
            valid_q <= 1'b0;
        end
    end

    assign FS_imemAddr    = pc_q;
    assign FS_PC          = pc_q;
    assign FS_instruction = insn_q;
    assign FS_pcPlus1     = pc_plus1_q;
    assign FS_valid       = valid_q;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Directed table-driven bench for fetch_stall_unit against a memory returning addr ^ 16'hA000.
module tb_fetch_stall_unit;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ready;
    logic [15:0] target;
    logic        imem_req;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] pc, insn, pc_plus1;
    logic        valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ 16'hA000;

    fetch_stall_unit dut (
        .FS_clk(clk),
        .FS_rst(rst),
        .FS_stall(stall),
        .FS_flush(flush),
        .FS_branchTarget(target),
        .FS_imemReq(imem_req),
        .FS_imemAddr(imem_addr),
        .FS_imemData(imem_data),
        .FS_imemReady(ready),
        .FS_PC(pc),
        .FS_instruction(insn),
        .FS_pcPlus1(pc_plus1),
        .FS_valid(valid)
    );

    typedef struct {
        logic        rst, stall, flush, ready;
        logic [15:0] tgt;
        logic [15:0] e_pc, e_insn, e_pp1;
        logic        e_valid, e_req;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic s, input logic f, input logic rdy,
                                input logic [15:0] t, input logic [15:0] epc, input logic [15:0] ei,
                                input logic [15:0] ep, input logic ev, input logic erq);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.ready = rdy; v.tgt = t;
        v.e_pc = epc; v.e_insn = ei; v.e_pp1 = ep; v.e_valid = ev; v.e_req = erq;
        vecs.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic s, input logic f, input logic rdy, input logic [15:0] t);
        rst = r; stall = s; flush = f; ready = rdy; target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] epc, input logic [15:0] ei,
                         input logic [15:0] ep, input logic ev, input logic erq);
        total++;
        if (pc !== epc || imem_addr !== epc || insn !== ei || pc_plus1 !== ep ||
            valid !== ev || imem_req !== erq) begin
            bad++;
            $display("FAIL %s: got pc=%h addr=%h insn=%h pp1=%h v=%b req=%b want pc=%h insn=%h pp1=%h v=%b req=%b",
                     name, pc, imem_addr, insn, pc_plus1, valid, imem_req, epc, ei, ep, ev, erq);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; ready = 1'b1; target = 16'h0000;

        //   rst stl fls rdy target    pc        insn      pp1       v  req
        add(1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0); // reset
        add(0, 0, 0, 1, 16'h0000, 16'h0001, 16'hA000, 16'h0001, 1, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0002, 16'hA001, 16'h0002, 1, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0003, 16'hA002, 16'h0003, 1, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0004, 16'hA003, 16'h0004, 1, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0005, 16'hA004, 16'h0005, 1, 1);
        add(0, 1, 0, 1, 16'h0000, 16'h0005, 16'hA004, 16'h0005, 1, 0); // stall at PC=5 -> HOLD
        add(0, 1, 0, 1, 16'h0000, 16'h0005, 16'hA004, 16'h0005, 1, 0);
        add(0, 1, 0, 1, 16'h0000, 16'h0005, 16'hA004, 16'h0005, 1, 0);
        add(0, 0, 0, 1, 16'h0000, 16'h0006, 16'hA005, 16'h0006, 1, 1); // release loads buffer
        add(0, 0, 0, 1, 16'h0000, 16'h0007, 16'hA006, 16'h0007, 1, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0008, 16'hA007, 16'h0008, 1, 1);
        add(0, 0, 0, 0, 16'h0000, 16'h0008, 16'h0800, 16'h0008, 0, 1); // wait bubbles
        add(0, 0, 0, 0, 16'h0000, 16'h0008, 16'h0800, 16'h0008, 0, 1);
        add(0, 0, 0, 1, 16'h0000, 16'h0009, 16'hA008, 16'h0009, 1, 1);
        add(0, 1, 0, 1, 16'h0000, 16'h0009, 16'hA008, 16'h0009, 1, 0); // HOLD
        add(0, 1, 1, 1, 16'h0040, 16'h0040, 16'h0800, 16'h0009, 0, 1); // flush beats stall
        add(0, 0, 0, 1, 16'h0000, 16'h0041, 16'hA040, 16'h0041, 1, 1);
        add(0, 0, 1, 1, 16'hFFFF, 16'hFFFF, 16'h0800, 16'h0041, 0, 1); // jump to top
        add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h5FFF, 16'h0000, 1, 1); // wrap
        add(0, 0, 0, 1, 16'h0000, 16'h0001, 16'hA000, 16'h0001, 1, 1);
        add(0, 1, 0, 1, 16'h0000, 16'h0001, 16'hA000, 16'h0001, 1, 0); // HOLD
        add(1, 1, 0, 1, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0); // reset in HOLD
        add(0, 0, 0, 1, 16'h0000, 16'h0001, 16'hA000, 16'h0001, 1, 1);
        add(0, 1, 0, 0, 16'h0000, 16'h0001, 16'hA000, 16'h0001, 1, 1); // stall, no completion
        add(0, 0, 1, 0, 16'h0010, 16'h0010, 16'h0800, 16'h0001, 0, 1); // flush mid-wait
        add(0, 0, 0, 1, 16'h0000, 16'h0011, 16'hA010, 16'h0011, 1, 1);
        add(0, 1, 1, 1, 16'h0020, 16'h0020, 16'h0800, 16'h0011, 0, 1); // flush+stall in FETCH
        add(0, 0, 0, 1, 16'h0000, 16'h0021, 16'hA020, 16'h0021, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].ready, vecs[i].tgt);
            check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_insn, vecs[i].e_pp1,
                  vecs[i].e_valid, vecs[i].e_req);
        end

        // Reset during a memory wait discards the in-flight word
        apply(0, 0, 0, 0, 16'h0000);
        check("wait_bubble", 16'h0021, 16'h0800, 16'h0021, 0, 1);
        apply(1, 0, 0, 1, 16'h0000);
        check("rst_mid_wait", 16'h0000, 16'h0800, 16'h0000, 0, 0);
        apply(0, 0, 0, 1, 16'h0000);
        check("restart0", 16'h0001, 16'hA000, 16'h0001, 1, 1);

        // Long hold with a flush arriving late: buffered word must not leak out
        apply(0, 1, 0, 1, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 1, 16'h0000);
            check($sformatf("long_hold%0d", k), 16'h0001, 16'hA000, 16'h0001, 1, 0);
        end
        apply(0, 0, 1, 0, 16'h0100);
        check("hold_flush", 16'h0100, 16'h0800, 16'h0001, 0, 1);
        apply(0, 0, 0, 1, 16'h0000);
        check("after_flush", 16'h0101, 16'hA100, 16'h0101, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stall_unit.md
# fetch_stall_unit

- Instruction-fetch stage of the 16-bit pipeline.
- Owns the PC register, the IF/ID pipeline register and the handshake to instruction memory.
- Consumes the stall request from the load-use hazard detector (hold PC and IF/ID) and the flush/redirect from branch resolution.
- Feeds the ID stage with an instruction or a NOP bubble every cycle, and buffers a fetched word when a stall arrives mid-fetch.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSN, 16'h0800, encoding driven into IF/ID on bubbles and flushes
- FS_clk  input  1  clock; all state updates on rising edge
- FS_rst  input  1  synchronous, active-high reset
- FS_stall  input  1  1 = hold PC and IF/ID (hazard detector's PCWrite/IFIDWrite hold request)
- FS_flush  input  1  1 = branch/jump taken; redirect PC, squash IF/ID
- FS_branchTarget  input  16  redirect address, sampled when FS_flush=1
- FS_imemReq  output  1  fetch request to instruction memory
- FS_imemAddr  output  16  fetch address (= PC)
- FS_imemData  input  16  instruction word, valid when FS_imemReady=1
- FS_imemReady  input  1  memory completes the request this cycle (may be low for any number of cycles, e.g. RAM shared with MEM stage)
- FS_PC  output  16  current PC register
- FS_instruction  output  16  IF/ID instruction register
- FS_pcPlus1  output  16  IF/ID PC+1 of the held instruction
- FS_valid  output  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Word addressing: next sequential PC = PC + 1, mod 2^16 (16'hFFFF wraps to 16'h0000).
- States: FETCH, HOLD. Reset state is FETCH.
- FS_imemReq = 1 in FETCH when FS_rst=0; 0 in HOLD and during reset. FS_imemAddr = FS_PC always.
- Priority at every edge: FS_rst > FS_flush > FS_stall > normal.
- FETCH, FS_imemReady=1:
  - flush: PC <= FS_branchTarget; IF/ID <= NOP_INSN, valid 0; fetched word discarded; stay FETCH.
  - stall: word captured into internal buffer; PC and IF/ID unchanged; go HOLD.
  - else: IF/ID <= FS_imemData, pcPlus1 <= PC+1, valid 1; PC <= PC+1; stay FETCH.
- FETCH, FS_imemReady=0:
  - flush: PC <= target; IF/ID <= NOP, valid 0; stay FETCH. The request is abandoned; memory must tolerate an address change while request is held.
  - stall: PC and IF/ID unchanged.
  - else: IF/ID <= NOP_INSN, valid 0, pcPlus1 unchanged; PC unchanged (bubble inserted).
- HOLD (no request issued):
  - flush: PC <= target; IF/ID <= NOP, valid 0; buffer dropped; go FETCH.
  - stall: stay HOLD, nothing changes.
  - else: IF/ID <= buffer, pcPlus1 <= PC+1, valid 1; PC <= PC+1; go FETCH.
- Hold semantics: while stalled, FS_instruction, FS_pcPlus1 and FS_valid keep their exact values (no NOP injection here; the ID/EX bubble belongs to the downstream register).

## Timing
- Reset values (edge with FS_rst=1, regardless of other inputs): FS_PC=RESET_PC; FS_instruction=NOP_INSN; FS_pcPlus1=16'h0000; FS_valid=0; state FETCH; buffer cleared. FS_imemReq=0 while FS_rst=1.
- All outputs except FS_imemReq and FS_imemAddr are registered. FS_imemReq is decoded from state and reset. FS_imemAddr is the PC register.
- Zero-wait memory (ready tied 1, no stall): one instruction per cycle. The word at address A appears on FS_instruction the cycle after FS_PC=A.
- Redirect latency: flush at edge N → FS_PC=target after N; target's instruction in IF/ID after edge N+1 (zero-wait). Exactly one squashed slot.
- Stall landing on a completing fetch costs no refetch: release edge loads the buffered word.
- Reset mid-HOLD or mid-wait: buffered/in-flight word discarded; fetch restarts at RESET_PC.

## Test plan
- Reset then zero-wait memory returning data = address XOR 16'hA000: FS_PC 0,1,2,… and FS_instruction 16'hA000,16'hA001,… with FS_valid=1 from the second cycle, FS_pcPlus1 = address+1.
- FS_stall=1 for 3 cycles while ready=1 at PC=5: state HOLD, FS_imemReq=0, IF/ID frozen at insn 4. On release, IF/ID=16'hA005, FS_PC=6, no duplicate or missing word.
- Ready low 2 cycles at PC=8, no stall: two NOP_INSN bubbles (FS_valid=0), then 16'hA008. FS_PC stays 8 until completion.
- FS_flush=1, target 16'h0040, simultaneous with FS_stall=1 in HOLD: FS_PC=16'h0040, IF/ID=16'h0800 valid 0, state FETCH, next insn 16'hA040.
- PC=16'hFFFF sequential fetch: FS_pcPlus1=16'h0000 and FS_PC wraps to 16'h0000.
- FS_rst asserted during HOLD with FS_stall=1: next cycle all outputs at reset values, FS_imemReq=0; after deassert, fetch from 16'h0000.
